// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - instruction bus and decode handshake bundle for the fetch stage
interface inst_fetch_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;
  logic        id_ready;

  modport master (
    output inst_req, inst_addr, if_valid, if_pc, if_inst, if_adel,
    input  inst_addr_ok, inst_rdata, inst_data_ok, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  inst_req, inst_addr, if_valid, if_pc, if_inst, if_adel,
    output inst_addr_ok, inst_rdata, inst_data_ok, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - PC sequencer, single-outstanding SRAM-like fetch and instruction buffer
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         resetn,
  inst_fetch_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

  state_e        fsm_q, fsm_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   pend_pc_q, pend_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          req_q, req_d;
  logic          stale_q, stale_d;
  logic          halt_q, halt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   mem_pc_q [FIFO_DEPTH];
  logic [31:0]   mem_pc_d [FIFO_DEPTH];
  logic [31:0]   mem_inst_q [FIFO_DEPTH];
  logic [31:0]   mem_inst_d [FIFO_DEPTH];
  logic          mem_adel_q [FIFO_DEPTH];
  logic          mem_adel_d [FIFO_DEPTH];
  logic          valid_q, valid_d;
  logic [31:0]   out_pc_q, out_pc_d, out_inst_q, out_inst_d;
  logic          out_adel_q, out_adel_d;

  logic          push, pop, space, push_adel;
  logic [31:0]   push_pc, push_inst;

  always_comb begin
    fsm_d     = fsm_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    addr_d    = addr_q;
    stale_d   = stale_q;
    halt_d    = halt_q;
    push      = 1'b0;
    push_pc   = pend_pc_q;
    push_inst = bus.inst_rdata;
    push_adel = 1'b0;
    pop       = valid_q && bus.id_ready;
    space     = count_q < CW'(FIFO_DEPTH);

    if (bus.redirect) begin
      pc_d   = bus.redirect_pc;
      halt_d = 1'b0;
    end

    case (fsm_q)
      IDLE: begin
        // A redirect empties the buffer, so an aligned target can be requested at once.
        if (bus.redirect) begin
          if (bus.redirect_pc[1:0] == 2'b00) begin
            fsm_d  = REQ;
            addr_d = bus.redirect_pc;
          end
        end else if (!halt_q && space) begin
          if (pc_q[1:0] != 2'b00) begin
            push      = 1'b1;
            push_pc   = pc_q;
            push_inst = 32'h0;
            push_adel = 1'b1;
            halt_d    = 1'b1;
          end else begin
            fsm_d  = REQ;
            addr_d = pc_q;
          end
        end
      end
      REQ: begin
        // A redirect seen while the address is still presented poisons the eventual response.
        if (bus.inst_addr_ok) begin
          pend_pc_d = addr_q;
          stale_d   = 1'b0;
          if (bus.redirect || stale_q) begin
            fsm_d = DROP;
          end else begin
            fsm_d = WAIT;
            pc_d  = pc_q + 32'd4;
          end
        end else if (bus.redirect) begin
          stale_d = 1'b1;
        end
      end
      WAIT: begin
        if (bus.inst_data_ok) begin
          fsm_d = IDLE;
          push  = !bus.redirect;
        end else if (bus.redirect) begin
          fsm_d = DROP;
        end
      end
      DROP: begin
        if (bus.inst_data_ok) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_pc_d   = mem_pc_q;
    mem_inst_d = mem_inst_q;
    mem_adel_d = mem_adel_q;
    if (bus.redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_pc_d[wr_ptr_q]   = push_pc;
        mem_inst_d[wr_ptr_q] = push_inst;
        mem_adel_d[wr_ptr_q] = push_adel;
        wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end

    // Head outputs are registered and simply hold while the buffer is empty.
    valid_d    = count_d != '0;
    out_pc_d   = out_pc_q;
    out_inst_d = out_inst_q;
    out_adel_d = out_adel_q;
    if (valid_d) begin
      out_pc_d   = mem_pc_d[rd_ptr_d];
      out_inst_d = mem_inst_d[rd_ptr_d];
      out_adel_d = mem_adel_d[rd_ptr_d];
    end

    req_d = fsm_d == REQ;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fsm_q      <= IDLE;
      pc_q       <= RESET_PC;
      pend_pc_q  <= '0;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      stale_q    <= 1'b0;
      halt_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      mem_pc_q   <= '{default: '0};
      mem_inst_q <= '{default: '0};
      mem_adel_q <= '{default: 1'b0};
      valid_q    <= 1'b0;
      out_pc_q   <= '0;
      out_inst_q <= '0;
      out_adel_q <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      stale_q    <= stale_d;
      halt_q     <= halt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_pc_q   <= mem_pc_d;
      mem_inst_q <= mem_inst_d;
      mem_adel_q <= mem_adel_d;
      valid_q    <= valid_d;
      out_pc_q   <= out_pc_d;
      out_inst_q <= out_inst_d;
      out_adel_q <= out_adel_d;
    end
  end

  assign bus.inst_req  = req_q;
  assign bus.inst_addr = addr_q;
  assign bus.if_valid  = valid_q;
  assign bus.if_pc     = out_pc_q;
  assign bus.if_inst   = out_inst_q;
  assign bus.if_adel   = out_adel_q;
endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard bench for inst_fetch with a modelled SRAM-like responder
module tb_inst_fetch;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } exp_t;

  logic clk;
  logic resetn;
  inst_fetch_if bus();

  inst_fetch #(.RESET_PC(32'hBFC0_0000), .FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        exp_q[$];
  logic [31:0] aok_log[$];
  int          aok_cnt, del_cnt, pend_cnt, dok_delay;
  logic        pend_valid, pend_stale, req_stale, hold_aok, ready, rd_req;
  logic [31:0] pend_addr, rd_pc, last_del_pc, first_del_pc;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  task automatic clear_model();
    exp_q.delete();
    aok_log.delete();
    aok_cnt = 0; del_cnt = 0; pend_cnt = 0;
    pend_valid = 1'b0; pend_stale = 1'b0; req_stale = 1'b0;
    pend_addr = '0; last_del_pc = '0; first_del_pc = '0;
  endtask

  // One cycle: sample outputs at negedge, drive responder/decode inputs, update the scoreboard.
  task automatic step();
    exp_t e;
    logic aok, dok;
    @(negedge clk);
    aok = 1'b0;
    dok = 1'b0;
    if (resetn) begin
      if (pend_valid) begin
        if (pend_cnt == 0) dok = 1'b1;
        else pend_cnt--;
      end
      if (bus.inst_req && !hold_aok && !pend_valid) aok = 1'b1;
    end
    bus.inst_addr_ok = aok;
    bus.inst_data_ok = dok;
    bus.inst_rdata   = dok ? word_of(pend_addr) : 32'hDEAD_BEEF;
    bus.redirect     = resetn && rd_req;
    bus.redirect_pc  = rd_pc;
    bus.id_ready     = resetn && ready;
    if (bus.redirect) begin
      if (bus.inst_req) req_stale = 1'b1;
      if (pend_valid) pend_stale = 1'b1;
    end
    if (resetn && bus.if_valid && bus.id_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL deliver_extra: got pc=%h inst=%h adel=%b, required no entry", bus.if_pc, bus.if_inst, bus.if_adel);
      end else begin
        e = exp_q.pop_front();
        if (bus.if_pc !== e.pc || bus.if_inst !== e.inst || bus.if_adel !== e.adel) begin
          n_err++;
          $display("FAIL deliver: got pc=%h inst=%h adel=%b, required pc=%h inst=%h adel=%b",
                   bus.if_pc, bus.if_inst, bus.if_adel, e.pc, e.inst, e.adel);
        end
      end
      if (del_cnt == 0) first_del_pc = bus.if_pc;
      del_cnt++;
      last_del_pc = bus.if_pc;
    end
    if (dok) begin
      if (!pend_stale) begin
        e.pc = pend_addr; e.inst = word_of(pend_addr); e.adel = 1'b0;
        exp_q.push_back(e);
      end
      pend_valid = 1'b0;
    end
    if (aok) begin
      pend_valid = 1'b1;
      pend_addr  = bus.inst_addr;
      pend_stale = req_stale;
      pend_cnt   = dok_delay;
      req_stale  = 1'b0;
      aok_cnt++;
      aok_log.push_back(bus.inst_addr);
    end
    if (bus.redirect) begin
      exp_q.delete();
      if (rd_pc[1:0] != 2'b00) begin
        e.pc = rd_pc; e.inst = 32'h0; e.adel = 1'b1;
        exp_q.push_back(e);
      end
    end
    rd_req = 1'b0;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    repeat (3) step();
    clear_model();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    hold_aok = 1'b0; dok_delay = 0; ready = 1'b1;
    apply_reset();
    n_cmp++; if (bus.inst_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b, required 0", bus.inst_req); end
    n_cmp++; if (bus.inst_addr !== 32'hBFC0_0000) begin n_err++; $display("FAIL rst_addr: got %h, required bfc00000", bus.inst_addr); end
    n_cmp++; if (bus.if_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b, required 0", bus.if_valid); end
    n_cmp++; if (bus.if_pc !== 32'h0 || bus.if_inst !== 32'h0 || bus.if_adel !== 1'b0) begin
      n_err++; $display("FAIL rst_if: got pc=%h inst=%h adel=%b, required zeros", bus.if_pc, bus.if_inst, bus.if_adel);
    end
    for (int i = 0; i < 40 && del_cnt < 3; i++) step();
    n_cmp++;
    if (aok_log.size() < 3 || del_cnt < 3) begin
      n_err++; $display("FAIL first_fetch_timeout: got %0d requests %0d deliveries, required 3/3", aok_log.size(), del_cnt);
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (aok_log[i] !== 32'hBFC0_0000 + 32'(4 * i)) begin
          n_err++; $display("FAIL first_fetch_addr%0d: got %h, required %h", i, aok_log[i], 32'hBFC0_0000 + 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    hold_aok = 1'b0; dok_delay = 0; ready = 1'b0;
    apply_reset();
    repeat (30) step();
    n_cmp++; if (aok_cnt != 2) begin n_err++; $display("FAIL bp_fetched: got %0d, required 2", aok_cnt); end
    n_cmp++; if (bus.inst_req !== 1'b0) begin n_err++; $display("FAIL bp_req_idle: got %b, required 0", bus.inst_req); end
    n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'hBFC0_0000) begin
      n_err++; $display("FAIL bp_head: got valid=%b pc=%h, required 1/bfc00000", bus.if_valid, bus.if_pc);
    end
    ready = 1'b1;
    for (int i = 0; i < 30 && aok_cnt < 3; i++) step();
    n_cmp++; if (del_cnt < 1 || first_del_pc !== 32'hBFC0_0000) begin
      n_err++; $display("FAIL bp_first_out: got %h (%0d delivered), required bfc00000", first_del_pc, del_cnt);
    end
    n_cmp++; if (aok_log.size() < 3 || aok_log[2] !== 32'hBFC0_0008) begin
      n_err++; $display("FAIL bp_resume: got %0d requests, required third at bfc00008", aok_log.size());
    end
  endtask

  task automatic test_redirect_wait();
    int d0;
    hold_aok = 1'b0; dok_delay = 2; ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 40 && aok_cnt < 3; i++) step();
    n_cmp++; if (aok_log.size() < 3 || aok_log[2] !== 32'hBFC0_0008) begin
      n_err++; $display("FAIL rw_inflight: got %0d requests, required third at bfc00008", aok_log.size());
    end
    rd_req = 1'b1; rd_pc = 32'hBFC0_0100;
    step();
    d0 = del_cnt;
    for (int i = 0; i < 30 && (aok_cnt < 4 || del_cnt <= d0); i++) step();
    n_cmp++; if (aok_log.size() < 4 || aok_log[3] !== 32'hBFC0_0100) begin
      n_err++; $display("FAIL rw_next_addr: got %0d requests, required fourth at bfc00100", aok_log.size());
    end
    n_cmp++; if (del_cnt <= d0 || last_del_pc !== 32'hBFC0_0100) begin
      n_err++; $display("FAIL rw_next_pc: got %h, required bfc00100", last_del_pc);
    end
  endtask

  task automatic test_redirect_req();
    logic [31:0] a;
    hold_aok = 1'b1; dok_delay = 0; ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 10 && !bus.inst_req; i++) step();
    a = bus.inst_addr;
    rd_req = 1'b1; rd_pc = 32'hBFC0_0200;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== a) begin
        n_err++; $display("FAIL rq_hold%0d: got req=%b addr=%h, required 1/%h", i, bus.inst_req, bus.inst_addr, a);
      end
    end
    hold_aok = 1'b0;
    for (int i = 0; i < 30 && (aok_cnt < 2 || del_cnt < 1); i++) step();
    n_cmp++; if (aok_log.size() < 2 || aok_log[0] !== a || aok_log[1] !== 32'hBFC0_0200) begin
      n_err++; $display("FAIL rq_addrs: got %0d requests, required %h then bfc00200", aok_log.size(), a);
    end
    n_cmp++; if (del_cnt < 1 || first_del_pc !== 32'hBFC0_0200) begin
      n_err++; $display("FAIL rq_first_out: got %h, required bfc00200", first_del_pc);
    end
  endtask

  task automatic test_simultaneous();
    int d0;
    logic [31:0] h;
    hold_aok = 1'b0; dok_delay = 0; ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 20 && aok_cnt < 2; i++) step();
    rd_req = 1'b1; rd_pc = 32'hBFC0_0300;
    step();
    d0 = del_cnt;
    for (int i = 0; i < 20 && del_cnt <= d0; i++) step();
    n_cmp++; if (del_cnt <= d0 || last_del_pc !== 32'hBFC0_0300) begin
      n_err++; $display("FAIL sim_redir_data: got %h, required bfc00300", last_del_pc);
    end
    ready = 1'b0;
    for (int i = 0; i < 20 && !bus.if_valid; i++) step();
    for (int i = 0; i < 20 && !(pend_valid && pend_cnt == 0); i++) step();
    h = bus.if_pc;
    ready = 1'b1;
    step();
    ready = 1'b0;
    step();
    n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== h + 32'd4) begin
      n_err++; $display("FAIL sim_push_pop: got valid=%b pc=%h, required 1/%h", bus.if_valid, bus.if_pc, h + 32'd4);
    end
  endtask

  task automatic test_misaligned();
    int reqs;
    int c;
    hold_aok = 1'b0; dok_delay = 0; ready = 1'b1;
    rd_req = 1'b1; rd_pc = 32'h0040_0002;
    step();
    for (int i = 0; i < 20 && !(bus.if_valid && bus.if_adel); i++) step();
    n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_adel !== 1'b1 || bus.if_pc !== 32'h0040_0002 || bus.if_inst !== 32'h0) begin
      n_err++; $display("FAIL mis_entry: got valid=%b adel=%b pc=%h inst=%h, required 1/1/00400002/0",
                        bus.if_valid, bus.if_adel, bus.if_pc, bus.if_inst);
    end
    reqs = 0;
    repeat (20) begin
      step();
      if (bus.inst_req) reqs++;
    end
    n_cmp++; if (reqs != 0) begin n_err++; $display("FAIL mis_stall: got %0d request cycles, required 0", reqs); end
    c = aok_cnt;
    rd_req = 1'b1; rd_pc = 32'hBFC0_0400;
    step();
    for (int i = 0; i < 20 && aok_cnt <= c; i++) step();
    n_cmp++; if (aok_cnt <= c || aok_log[c] !== 32'hBFC0_0400) begin
      n_err++; $display("FAIL mis_resume: got %0d new requests, required one at bfc00400", aok_cnt - c);
    end
  endtask

  initial begin
    resetn = 1'b0;
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = '0;
    bus.redirect = 1'b0; bus.redirect_pc = '0; bus.id_ready = 1'b0;
    rd_req = 1'b0; rd_pc = '0; hold_aok = 1'b0; ready = 1'b0; dok_delay = 0;
    clear_model();
    test_reset();
    test_backpressure();
    test_redirect_wait();
    test_redirect_req();
    test_simultaneous();
    test_misaligned();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage feeding the main decoder. Generates the PC sequence and issues requests on the SRAM-like instruction bus (`req`/`addr_ok`/`data_ok`). Buffers returned words in a small FIFO and presents `{pc, inst}` to decode over a valid/ready handshake. Decode redirects fetch for taken branches, jumps and `jr`/`jalr`.

## Interface

**Parameters** (name, default, meaning)
- `RESET_PC`, `32'hBFC0_0000`, first fetch address after reset
- `FIFO_DEPTH`, 2, number of instruction buffer entries; power of two, ≥2

**Ports** (name, direction, width, meaning)
- `clk`, in, 1, single clock; all logic is rising-edge
- `resetn`, in, 1, reset, synchronous and active-low
- `inst_req`, out, 1, request valid
- `inst_addr`, out, 32, request address; word aligned
- `inst_addr_ok`, in, 1, request accepted this cycle
- `inst_rdata`, in, 32, returned instruction
- `inst_data_ok`, in, 1, `inst_rdata` valid this cycle
- `redirect`, in, 1, flush and refetch from `redirect_pc`
- `redirect_pc`, in, 32, target address
- `if_valid`, out, 1, FIFO head valid to decode
- `if_pc`, out, 32, PC of head entry
- `if_inst`, out, 32, instruction of head entry; 0 when `if_adel`
- `if_adel`, out, 1, head entry's PC was misaligned
- `id_ready`, in, 1, decode accepts the head this cycle

## Operation

- Registers:
  - `pc`
  - FIFO with read/write pointers and a count of width log2(FIFO_DEPTH)+1
  - `pend_pc`
  - `fsm` with states IDLE, REQ, WAIT, DROP
- At most one request is outstanding at a time. A slot is reserved at issue, so a request is issued only when `count + (fsm==WAIT) < FIFO_DEPTH`.
- **IDLE**
  - If `pc[1:0]!=0`: push `{pc, 0, adel=1}` when space is free, then hold. Fetch stays stalled until the next redirect.
  - Otherwise, when space is free, go to REQ.
- **REQ**
  - `inst_req=1` and `inst_addr=pc`. Both are held stable until `inst_addr_ok`.
  - On `inst_addr_ok`: `pend_pc<=pc`, `pc<=pc+4` (32-bit wrap), go to WAIT.
- **WAIT**
  - On `inst_data_ok`: push `{pend_pc, inst_rdata, 0}`, go to IDLE.
- **DROP**
  - On `inst_data_ok`: discard the data, go to IDLE.
- **Redirect** (decode raises it only after accepting the delay-slot instruction):
  - FIFO cleared: count=0, pointers reset.
  - `pc<=redirect_pc`.
  - In WAIT: go to DROP, unless `inst_data_ok` is also high that cycle, in which case the data is dropped and fsm goes to IDLE.
  - In REQ with `inst_addr_ok`: go to DROP; `pc` still becomes `redirect_pc`.
  - In REQ without `inst_addr_ok`: stay in REQ with address unchanged. On acceptance go to DROP and keep `pc=redirect_pc` (no +4).
  - In DROP: stay in DROP; the target is updated to the newest redirect.
  - In IDLE: the target takes effect immediately.
- **Output side:**
  - Dequeue when `if_valid && id_ready`.
  - Push and pop in the same cycle: count unchanged.
  - Redirect overrides push and pop in the same cycle; the popped entry still counts as delivered.

## Timing

- **Reset values:** `inst_req=0`, `inst_addr=RESET_PC`, `if_valid=0`, `if_pc=0`, `if_inst=0`, `if_adel=0`, fsm=IDLE, count=0, `pc=RESET_PC`.
- **Reset mid-operation:** all state returns to reset values on the next edge. A pending `data_ok` after reset is ignored; fsm is IDLE, not WAIT.
- **Startup:** `inst_req` rises in the 2nd cycle after `resetn` is sampled high (IDLE→REQ takes 1 cycle).
- **FIFO timing:**
  - The FIFO is registered; an entry pushed in cycle N is visible on `if_*` in cycle N+1.
  - With 1-cycle `addr_ok` and 1-cycle `data_ok`, steady-state throughput is one instruction per 3 cycles (IDLE, REQ, WAIT).
- **Redirect timing:**
  - Redirect-to-first-`inst_req` on the target is 1 cycle from IDLE.
  - Redirect-to-first-`inst_req` on the target is 1 cycle after the dropped `data_ok` from WAIT/DROP.
- **Full/empty:**
  - FIFO full with count=FIFO_DEPTH: fsm stays in IDLE and `inst_req=0`.
  - FIFO empty: `if_valid=0`; `if_*` data is don't-care but holds its last value.
- **Overrun:** `inst_data_ok` in IDLE/REQ is a protocol error and is ignored.

## Test plan

- **Reset and first fetch:** hold `resetn=0` for 3 cycles, `addr_ok`/`data_ok` 1-cycle.
  - `inst_addr` sequence is 0xBFC00000, 0xBFC00004, 0xBFC00008.
  - `if_pc` matches, each with the correct `if_inst`.
- **Backpressure:** `id_ready=0` with `FIFO_DEPTH=2`.
  - Exactly 2 entries are fetched, then `inst_req` stays 0.
  - Raising `id_ready` delivers 0xBFC00000 first, in order.
- **Redirect while in WAIT:** `redirect_pc=0xBFC00100`.
  - The in-flight word (0xBFC00008) is dropped and the FIFO is flushed.
  - Next `inst_addr` is 0xBFC00100.
  - Next `if_pc` is 0xBFC00100.
- **Redirect in REQ without `addr_ok`:**
  - `inst_addr` stays at its old value until accepted.
  - The response is dropped, then the target is fetched.
- **Simultaneous events:**
  - `redirect` + `inst_data_ok` in the same cycle: the data never appears on `if_*`.
  - Push + pop in the same cycle with count=1: count stays 1.
- **Misaligned target:** `redirect_pc=0x00400002`.
  - `if_valid=1`, `if_adel=1`, `if_pc=0x00400002`, `if_inst=0`.
  - No `inst_req` is issued until the next redirect.
